// File: rtl/toggle_cover_collector.sv
// rtl/toggle_cover_collector.sv - sticky toggle-coverage map with an in-order stream of newly covered indices
// Each point is reported exactly once; the pending map holds hits that are waiting for the stream.
module toggle_cover_collector #(
  parameter int WIDTH       = 2,
  parameter int COVER_INDEX = 0,
  parameter int IDX_W       = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           valid,
  input  logic                       enable,
  input  logic                       clear,
  output logic [WIDTH-1:0]           covered,
  output logic [$clog2(WIDTH+1)-1:0] covered_count,
  output logic                       all_covered,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IDX_W-1:0]           out_index
);

  localparam int CW = $clog2(WIDTH+1);
  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] COVER_BASE = IDX_W'(COVER_INDEX);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t          state;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] new_hits;
  logic [WIDTH-1:0] pool;
  logic [WIDTH-1:0] pick_onehot;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;
  logic             slot_free;
  logic [CW-1:0]    hit_count;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  assign new_hits    = valid & ~covered & {WIDTH{enable}};
  assign hit_count   = popcount(new_hits);
  assign all_covered = (covered_count == CW'(WIDTH));

  // An idle stream may present a hit the cycle after it arrives; while presenting,
  // fresh hits only join pending and become selectable a cycle later.
  assign slot_free = (state == IDLE) || out_ready;
  assign pool      = (state == IDLE) ? (pending | new_hits) : pending;

  always_comb begin
    pick_idx    = '0;
    pick_onehot = '0;
    pick_any    = |pool;
    for (int i = WIDTH-1; i >= 0; i--) begin
      if (pool[i]) begin
        pick_idx    = PW'(i);
        pick_onehot = '0;
        pick_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      covered       <= '0;
      covered_count <= '0;
      pending       <= '0;
      state         <= IDLE;
      out_valid     <= 1'b0;
      out_index     <= '0;
    end else begin
      covered       <= covered | new_hits;
      covered_count <= covered_count + hit_count;
      if (slot_free) begin
        if (pick_any) begin
          out_index <= COVER_BASE + IDX_W'(pick_idx);
          out_valid <= 1'b1;
          state     <= PRESENT;
          pending   <= (pending | new_hits) & ~pick_onehot;
        end else begin
          out_valid <= 1'b0;
          state     <= IDLE;
          pending   <= pending | new_hits;
        end
      end else begin
        pending <= pending | new_hits;
      end
    end
  end

endmodule

// File: tb/tb_toggle_cover_collector.sv
// tb/tb_toggle_cover_collector.sv - scoreboard bench for toggle_cover_collector (WIDTH=4, COVER_INDEX=100)
module tb_toggle_cover_collector;

  logic        clock;
  logic        reset;
  logic [3:0]  valid;
  logic        enable;
  logic        clear;
  logic [3:0]  covered;
  logic [2:0]  covered_count;
  logic        all_covered;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_index;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  toggle_cover_collector #(.WIDTH(4), .COVER_INDEX(100), .IDX_W(32)) dut (
    .clock(clock), .reset(reset), .valid(valid), .enable(enable), .clear(clear),
    .covered(covered), .covered_count(covered_count), .all_covered(all_covered),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(i);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s drain_timeout actual=%0d expected=0 left", name, exp_q.size());
    end
    tick();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Monitor: every accepted beat must match the oldest expected index.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual=%0d expected=none", out_index);
      end else begin
        chk("out_index", out_index, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; valid = '0; enable = 1'b1; clear = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_covered", covered, 0);
    chk("rst_count", covered_count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_all_covered", all_covered, 0);
    reset = 1'b0;
    tick();

    // single hit, one-cycle latency
    valid = 4'b0010; exp_q.push_back(101);
    tick();
    valid = '0;
    chk("t1_covered", covered, 4'b0010);
    chk("t1_count", covered_count, 1);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_index", out_index, 101);
    tick();
    chk("t1_idle", out_valid, 0);

    // simultaneous hits reported ascending, back-to-back
    pulse_clear();
    valid = 4'b1011; exp_q.push_back(100); exp_q.push_back(101); exp_q.push_back(103);
    tick();
    valid = '0;
    chk("t2_idx0", out_index, 100);
    tick();
    chk("t2_idx1", out_index, 101);
    tick();
    chk("t2_idx2", out_index, 103);
    chk("t2_valid2", out_valid, 1);
    tick();
    chk("t2_idle", out_valid, 0);
    chk("t2_count", covered_count, 3);

    // backpressure holds the index; a re-hit is not reported again
    pulse_clear();
    out_ready = 1'b0;
    valid = 4'b0100; exp_q.push_back(102);
    tick();
    valid = '0;
    for (int c = 0; c < 5; c++) begin
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_index", out_index, 102);
      valid = (c == 2) ? 4'b0100 : 4'b0000;
      tick();
    end
    valid = '0;
    chk("t3_count", covered_count, 1);
    out_ready = 1'b1;
    tick();
    chk("t3_single_hs", out_valid, 0);
    tick();
    chk("t3_still_idle", out_valid, 0);

    // full coverage, then clear with hits in the clear cycle
    pulse_clear();
    valid = 4'b1111; push_range(100, 103);
    tick();
    valid = '0;
    drain("t4");
    chk("t4_all_covered", all_covered, 1);
    chk("t4_count", covered_count, 4);
    clear = 1'b1; valid = 4'b1111;
    tick();
    clear = 1'b0; valid = '0;
    chk("t4_clr_covered", covered, 0);
    chk("t4_clr_count", covered_count, 0);
    chk("t4_clr_out_valid", out_valid, 0);
    chk("t4_clr_all", all_covered, 0);

    // enable low blocks hits
    enable = 1'b0; valid = 4'b1111;
    tick(); tick(); tick();
    valid = '0;
    chk("t5_blk_covered", covered, 0);
    chk("t5_blk_out_valid", out_valid, 0);
    enable = 1'b1; valid = 4'b1111; push_range(100, 103);
    tick();
    valid = '0;
    drain("t5");
    chk("t5_count", covered_count, 4);

    // clear while presenting drops the index
    pulse_clear();
    out_ready = 1'b0;
    valid = 4'b0001;
    tick();
    valid = '0;
    chk("t7_present", out_valid, 1);
    pulse_clear();
    chk("t7_dropped", out_valid, 0);
    out_ready = 1'b1;
    tick(); tick();
    chk("t7_idle", out_valid, 0);

    // reset mid-drain discards pending indices
    out_ready = 1'b0;
    valid = 4'b0111;
    tick();
    valid = '0;
    chk("t6_present", out_valid, 1);
    chk("t6_index", out_index, 100);
    reset = 1'b1;
    tick();
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_covered", covered, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    chk("t6_no_emit", out_valid, 0);
    chk("t6_count", covered_count, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
